// File: rtl/multi_tap_delayed_fifo.sv
// Ring-buffer delay line with TAPS independently delayed read ports.
// Each UPDATE writes one sample and registers every tap's delayed view.
module multi_tap_delayed_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128,
    parameter int TAPS  = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              UPDATE,
    input  logic [TAPS*$clog2(DEPTH)-1:0]     DELAY,
    input  logic [WIDTH-1:0]                  DATA_IN,
    output logic [TAPS*WIDTH-1:0]             DATA_OUT,
    output logic [TAPS-1:0]                   VALID
);
    localparam int DW = $clog2(DEPTH);

    logic [WIDTH-1:0]             mem [DEPTH];
    logic [DW-1:0]                wp;
    logic [DW-1:0]                n;
    logic [TAPS-1:0][DW-1:0]      dly;
    logic [TAPS-1:0][DW-1:0]      ra;
    logic [TAPS-1:0][WIDTH-1:0]   dout;

    assign DATA_OUT = dout;

    // Read address uses the pre-write pointer, so d=DEPTH-1 reaches the
    // oldest sample rather than the slot being overwritten this cycle.
    always_comb begin
        dly = '0;
        ra  = '0;
        for (int i = 0; i < TAPS; i++) begin
            dly[i] = DELAY[i*DW +: DW];
            ra[i]  = wp - dly[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wp <= '0;
            n  <= '0;
        end else if (UPDATE) begin
            mem[wp] <= DATA_IN;
            wp      <= wp + 1'b1;
            if (n != DW'(DEPTH - 1))
                n <= n + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dout  <= '0;
            VALID <= '0;
        end else if (UPDATE) begin
            for (int i = 0; i < TAPS; i++) begin
                if (dly[i] > n) begin
                    dout[i]  <= '0;
                    VALID[i] <= 1'b0;
                end else if (dly[i] == '0) begin
                    dout[i]  <= DATA_IN;
                    VALID[i] <= 1'b1;
                end else begin
                    dout[i]  <= mem[ra[i]];
                    VALID[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/multi_tap_delayed_fifo.md
MULTI_TAP_DELAYED_FIFO -- requirements
Module: multi_tap_delayed_fifo

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one sample (e.g. {duty, phase}).
REQ-002 Parameter DEPTH, default 128, ring-buffer depth in samples; SHALL be a power of two and at least 2.
REQ-003 Parameter TAPS, default 2, number of independently delayed outputs sharing one input stream.
REQ-004 Derived DW = log2(DEPTH), width of one delay value (7 at default).
REQ-005 CLK  input  1  system clock; all logic on rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 UPDATE  input  1  single-cycle strobe, once per ultrasound period; advances the delay line.
REQ-008 DELAY  input  TAPS*DW  packed per-tap delay in UPDATE periods; tap i at bits [i*DW +: DW].
REQ-009 DATA_IN  input  WIDTH  sample written on UPDATE.
REQ-010 DATA_OUT  output  TAPS*WIDTH  packed per-tap delayed sample; tap i at bits [i*WIDTH +: WIDTH].
REQ-011 VALID  output  TAPS  per-tap flag; high when DATA_OUT for that tap holds a real sample.

Function
REQ-012 Storage SHALL be one DEPTH x WIDTH ring buffer with write pointer wp (DW bits, wraps DEPTH-1 -> 0) and fill counter n (0..DEPTH-1, saturating at DEPTH-1).
REQ-013 On a clock with UPDATE=1 and RST=0: mem[wp] <= DATA_IN; wp <= wp+1 mod DEPTH; n <= min(n+1, DEPTH-1).
REQ-014 On the same clock, each tap i with d = DELAY[i] SHALL register DATA_OUT[i] <= DATA_IN if d=0, else mem[(wp-d) mod DEPTH] (pre-write contents).
REQ-015 On the same clock, VALID[i] <= (d <= n) using n before increment; if d > n then DATA_OUT[i] <= 0 and VALID[i] <= 0.
REQ-016 Latency: DATA_OUT/VALID change exactly one clock after the UPDATE edge, i.e. visible from the clock following UPDATE; with delay d the output equals the sample written d UPDATEs earlier.
REQ-017 DELAY SHALL be sampled only on UPDATE clocks; DELAY changes between UPDATEs have no effect until the next UPDATE.
REQ-018 Between UPDATEs, DATA_OUT, VALID, wp, n and memory SHALL hold.
REQ-019 Delay change at UPDATE: new d takes effect immediately at that UPDATE; reducing d skips samples, increasing d repeats earlier samples; VALID re-evaluated per REQ-015.
REQ-020 Maximum delay DEPTH-1 SHALL be exact at wrap-around: after >= DEPTH-1 writes, d=DEPTH-1 returns the oldest sample, never the one being written.
REQ-021 Taps SHALL be fully independent; any taps may share the same delay value.
REQ-022 UPDATE asserted on consecutive clocks SHALL be processed each clock (no lost writes).
REQ-023 Memory contents need not be reset; VALID/n masking guarantees uninitialised entries never reach DATA_OUT.

Reset
REQ-024 RST=1 at a clock edge SHALL set wp=0, n=0, DATA_OUT=0, VALID=0 on the following cycle.
REQ-025 RST SHALL take priority over a simultaneous UPDATE; that UPDATE's sample is discarded.
REQ-026 RST mid-stream SHALL fully restart history: after release, tap with d>0 shows VALID=0 until d further UPDATEs have occurred.

Verification
REQ-027 Defaults, DELAY={2,1}, DATA_IN=k at k-th UPDATE (k=1..10) -> after UPDATE 5: tap0 = 3 VALID=1, tap1 = 4 VALID=1; after UPDATE 1: tap0 0/VALID 0, tap1 0/VALID 0; after UPDATE 2: tap1 = 1 VALID=1, tap0 still VALID=0.
REQ-028 DELAY={0,127}, 200 UPDATEs of DATA_IN=k -> at UPDATE 200: tap0 = 200, tap1 = 73 VALID=1; tap1 VALID first rises at UPDATE 128 with value 1.
REQ-029 After 20 UPDATEs with DELAY={3,3}, change DELAY to {7,1} mid-period -> outputs unchanged until next UPDATE (21): tap0 = 14, tap1 = 20.
REQ-030 RST pulsed in same clock as UPDATE 15 with DELAY={1,2} -> DATA_OUT=0, VALID=0; next UPDATE (DATA_IN=16) gives VALID=00; following UPDATE (17) gives tap0 = 16 VALID=1, tap1 VALID=0.
REQ-031 Back-to-back UPDATE on 4 consecutive clocks, DATA_IN=0xA1..0xA4, DELAY={1,0} -> on 4th output cycle tap0 = 0xA3, tap1 = 0xA4; no sample skipped.
REQ-032 Idle 5120 clocks without UPDATE -> DATA_OUT, VALID bit-identical throughout.
